// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: register-array storage, wrap-bit pointers, registered status.
// Compile with FIFO_FWFT_EN defined for first-word-fall-through read data.

module sync_fifo_ctrl_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Storage is intentionally unreset; pointers define which entries are live.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module sync_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH-2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T = CW'(AE_THRESH);

  logic [AW:0]                  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]                count_nxt;
  logic                         full_nxt, empty_nxt, af_nxt, ae_nxt;
  logic                         wr_acc, rd_acc, wr_go, rd_go;
  logic [DEPTH-1:0]             mem_we;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  // flush wins: nothing is accepted or flagged in a flush cycle
  assign wr_go  = wr_acc & ~flush;
  assign rd_go  = rd_acc & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign mem_we[g] = wr_go && (wr_ptr[AW-1:0] == AW'(g));
    sync_fifo_ctrl_entry #(.WIDTH(WIDTH)) u_ent (
      .clk (clk),
      .we  (mem_we[g]),
      .d   (wdata),
      .q   (mem_q[g])
    );
  end

  always_comb begin
    wr_ptr_nxt = flush ? '0 : wr_ptr + CW'(wr_go);
    rd_ptr_nxt = flush ? '0 : rd_ptr + CW'(rd_go);
    count_nxt  = count;
    if (flush)               count_nxt = '0;
    else if (wr_go && !rd_go) count_nxt = count + CW'(1);
    else if (rd_go && !wr_go) count_nxt = count - CW'(1);
    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    af_nxt    = (count_nxt >= AF_T);
    ae_nxt    = (count_nxt <= AE_T);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= af_nxt;
      almost_empty <= ae_nxt;
      overflow     <= ~flush & wr_en & ~wr_acc;
      underflow    <= ~flush & rd_en & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  logic [WIDTH-1:0] head_nxt;
  // A write landing on the next head slot is the only entry, so bypass it.
  assign head_nxt = (wr_go && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) ? wdata
                                                                      : mem_q[rd_ptr_nxt[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rdata <= '0;
    else if (!empty_nxt) rdata <= head_nxt;
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rdata <= '0;
    else if (rd_go) rdata <= mem_q[rd_ptr[AW-1:0]];
  end
`endif

endmodule
